// File: rtl/pll_phase_stepper.sv
// Dynamic PLL phase stepper: takes step commands, strobes phase_en/updn/cntsel,
// waits on the synchronised phase_done handshake, and tracks a signed position per counter.
module pll_phase_stepper #(
    parameter int unsigned PHASE_EN_CYCLES = 2,
    parameter int unsigned DONE_TIMEOUT    = 1023,
    parameter int unsigned NUM_CNT         = 8,
    parameter int unsigned POS_W           = 10
) (
    input  logic             scanclk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_cnt,
    input  logic             req_updn,
    input  logic [7:0]       req_steps,
    output logic             phase_en,
    output logic             updn,
    output logic [4:0]       cntsel,
    input  logic             phase_done,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_cnt,
    input  logic             err_clr,
    input  logic [2:0]       pos_sel,
    output logic [POS_W-1:0] pos_out
);

    localparam int unsigned EN_W = (PHASE_EN_CYCLES > 1) ? $clog2(PHASE_EN_CYCLES) : 1;
    localparam int unsigned TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [EN_W-1:0] EN_LAST = EN_W'(PHASE_EN_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        STROBE    = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [7:0]       steps_q, steps_d;
    logic [EN_W-1:0]  en_cnt_q, en_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             pd_meta_q, pd_meta_d;
    logic             pd_s_q, pd_s_d;
    logic             phase_en_q, phase_en_d;
    logic             done_q, done_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_cnt_q, err_cnt_d;
    logic [POS_W-1:0] pos_q [NUM_CNT];
    logic [POS_W-1:0] pos_d [NUM_CNT];
    logic [POS_W-1:0] pos_out_q, pos_out_d;

    logic set_err_cnt;
    logic set_err_to;
    logic step_ok;

    // Synchroniser idles high so a reset never looks like a completed step.
    always_comb begin
        pd_meta_d = phase_done;
        pd_s_d    = pd_meta_q;
    end

    always_ff @(posedge scanclk) begin
        if (rst) begin
            pd_meta_q <= 1'b1;
            pd_s_q    <= 1'b1;
        end else begin
            pd_meta_q <= pd_meta_d;
            pd_s_q    <= pd_s_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        steps_d     = steps_q;
        en_cnt_d    = en_cnt_q;
        to_cnt_d    = to_cnt_q;
        set_err_cnt = 1'b0;
        set_err_to  = 1'b0;
        step_ok     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d   = req_cnt;
                    dir_d   = req_updn;
                    steps_d = req_steps;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                en_cnt_d = '0;
                if (32'(cnt_q) >= NUM_CNT) begin
                    set_err_cnt = 1'b1;
                    state_d     = FINISH;
                end else if (steps_q == '0) begin
                    state_d = FINISH;
                end else begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (en_cnt_q == EN_LAST) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_LOW;
                end else begin
                    en_cnt_d = en_cnt_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!pd_s_q) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_HIGH;
                end else if (to_cnt_q == TO_LAST) begin
                    set_err_to = 1'b1;
                    state_d    = FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (pd_s_q) begin
                    step_ok  = 1'b1;
                    steps_d  = steps_q - 1'b1;
                    en_cnt_d = '0;
                    state_d  = (steps_q == 8'd1) ? FINISH : STROBE;
                end else if (to_cnt_q == TO_LAST) begin
                    set_err_to = 1'b1;
                    state_d    = FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so phase_en drops on a reset edge.
    always_comb begin
        phase_en_d    = (state_d == STROBE);
        done_d        = (state_q == FINISH);
        err_cnt_d     = err_clr ? 1'b0 : (err_cnt_q | set_err_cnt);
        err_timeout_d = err_clr ? 1'b0 : (err_timeout_q | set_err_to);
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            pos_d[i] = pos_q[i];
            if (step_ok && (32'(cnt_q) == i)) begin
                pos_d[i] = dir_q ? (pos_q[i] + 1'b1) : (pos_q[i] - 1'b1);
            end
        end
        pos_out_d = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (32'(pos_sel) == i) begin
                pos_out_d = pos_q[i];
            end
        end
    end

    always_ff @(posedge scanclk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dir_q         <= 1'b0;
            steps_q       <= '0;
            en_cnt_q      <= '0;
            to_cnt_q      <= '0;
            phase_en_q    <= 1'b0;
            done_q        <= 1'b0;
            err_cnt_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            pos_out_q     <= '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            steps_q       <= steps_d;
            en_cnt_q      <= en_cnt_d;
            to_cnt_q      <= to_cnt_d;
            phase_en_q    <= phase_en_d;
            done_q        <= done_d;
            err_cnt_q     <= err_cnt_d;
            err_timeout_q <= err_timeout_d;
            pos_out_q     <= pos_out_d;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign phase_en    = phase_en_q;
    assign done        = done_q;
    assign err_cnt     = err_cnt_q;
    assign err_timeout = err_timeout_q;
    assign cntsel      = cnt_q;
    assign updn        = dir_q;
    assign pos_out     = pos_out_q;

endmodule

// File: doc/pll_phase_stepper.md
PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 The block SHALL have parameter PHASE_EN_CYCLES, default 2, giving the number of scanclk cycles phase_en is held high per step.
REQ-002 The block SHALL have parameter DONE_TIMEOUT, default 1023, giving the maximum number of scanclk cycles to wait in each phase_done phase.
REQ-003 The block SHALL have parameter NUM_CNT, default 8, giving the number of PLL output counters tracked.
REQ-004 The block SHALL have parameter POS_W, default 10, giving the width of each signed position accumulator.
REQ-005 Port scanclk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req_valid, input, 1 bit: command valid.
REQ-008 Port req_ready, output, 1 bit: command accepted when req_valid and req_ready are both high.
REQ-009 Port req_cnt, input, 5 bits: target counter select.
REQ-010 Port req_updn, input, 1 bit: direction; 1 = advance, 0 = retard.
REQ-011 Port req_steps, input, 8 bits: number of phase steps.
REQ-012 Port phase_en, output, 1 bit: phase-step strobe to the PLL.
REQ-013 Port updn, output, 1 bit: direction to the PLL.
REQ-014 Port cntsel, output, 5 bits: counter select to the PLL.
REQ-015 Port phase_done, input, 1 bit: PLL step-complete signal; it is asynchronous.
REQ-016 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-017 Port done, output, 1 bit: one-cycle pulse at the end of every accepted command.
REQ-018 Port err_timeout, output, 1 bit: sticky timeout flag.
REQ-019 Port err_cnt, output, 1 bit: sticky illegal-counter flag.
REQ-020 Port err_clr, input, 1 bit: clears both sticky error flags.
REQ-021 Port pos_sel, input, 3 bits: position readback select.
REQ-022 Port pos_out, output, POS_W bits: signed position of the counter selected by pos_sel.

Function
REQ-023 phase_done SHALL pass through a 2-flop synchronizer; only the synchronized value (pd_s) SHALL be used.
REQ-024 FSM states SHALL be IDLE, CHECK, STROBE, WAIT_LOW, WAIT_HIGH, FINISH.
REQ-025 req_ready SHALL be high only in IDLE.
REQ-026 On acceptance, req_cnt, req_updn and req_steps SHALL be latched, and the FSM SHALL go to CHECK.
REQ-027 In CHECK, if the latched req_cnt >= NUM_CNT, the block SHALL set err_cnt and go to FINISH without asserting phase_en.
REQ-028 In CHECK, if steps = 0, the block SHALL go to FINISH without asserting phase_en.
REQ-029 In CHECK, in all other cases, the block SHALL go to STROBE.
REQ-030 cntsel and updn SHALL be driven from the latched values from CHECK through FINISH, and SHALL be stable at least 1 cycle before phase_en rises.
REQ-031 In STROBE, phase_en SHALL be high for exactly PHASE_EN_CYCLES cycles; the FSM SHALL then go to WAIT_LOW.
REQ-032 WAIT_LOW SHALL wait for pd_s = 0, and WAIT_HIGH SHALL then wait for pd_s = 1.
REQ-033 A per-phase timeout counter SHALL clear on entry to WAIT_LOW and on entry to WAIT_HIGH.
REQ-034 If the timeout counter reaches DONE_TIMEOUT, the block SHALL set err_timeout, abandon the remaining steps, and go to FINISH.
REQ-035 A timed-out step SHALL NOT update the position.
REQ-036 When pd_s rises in WAIT_HIGH, the position of the latched counter SHALL update by +1 (updn = 1) or -1 (updn = 0), wrapping modulo 2^POS_W.
REQ-037 After the position update in WAIT_HIGH, the remaining step count SHALL decrement; the FSM SHALL go to STROBE if steps remain, else to FINISH.
REQ-038 FINISH SHALL pulse done for 1 cycle and return to IDLE.
REQ-039 Latency SHALL be 2 cycles from acceptance to done for zero-step and illegal commands.
REQ-040 pos_out SHALL be registered, with 1-cycle latency from pos_sel.
REQ-041 err_clr SHALL take priority over a simultaneous set of either sticky error flag.
REQ-042 req_valid SHALL be ignored while busy.

Reset
REQ-043 With rst high at a clock edge, the FSM SHALL go to IDLE.
REQ-044 On reset, phase_en, busy, done, err_timeout, err_cnt, updn and cntsel SHALL all be 0.
REQ-045 On reset, all position accumulators and pos_out SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-046 Reset during STROBE SHALL drop phase_en on that same edge; in-flight steps SHALL be discarded.
REQ-047 req_ready SHALL be high on the first cycle after reset deasserts.

Verification
REQ-048 Accept cnt=2, updn=1, steps=3; PLL model returns phase_done low 1 cycle and high 3 cycles after phase_en falls -> exactly 3 two-cycle phase_en pulses, one done pulse, and pos_out = 3 for pos_sel=2.
REQ-049 Accept cnt=2, updn=0, steps=5 after REQ-048 -> pos_out = -2 (0x3FE).
REQ-050 Accept cnt=9, steps=4 -> no phase_en, err_cnt = 1, done 2 cycles after acceptance; then err_clr -> err_cnt = 0.
REQ-051 Hold phase_done at 1 forever, steps=2 -> err_timeout = 1 after 1023 cycles in WAIT_LOW, one phase_en pulse only, position unchanged, one done pulse.
REQ-052 Accept steps=0 -> done 2 cycles after acceptance, with no phase_en.
REQ-053 Assert rst while phase_en is high -> phase_en = 0 next cycle, busy = 0, all positions 0, and req_ready = 1 after release.
REQ-054 Drive position to 511 on cnt=0, then advance 1 step -> pos_out = -512 (wrap-around).
